// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts a bubble on a hazard or flush and counts stall cycles.
module id_ex_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [2:0]       id_ALUOp,
   input  logic             id_RegDest,
   input  logic             id_RegWrite,
   input  logic             id_ALUSrc,
   input  logic             id_MemRead,
   input  logic             id_MemWrite,
   input  logic             id_MemToReg,
   input  logic             id_Branch,
   input  logic             id_Jump,
   input  logic [31:0]      id_pc4,
   input  logic [31:0]      id_rdata1,
   input  logic [31:0]      id_rdata2,
   input  logic [31:0]      id_imm,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic [5:0]       id_funct,
   input  logic             flush,
   output logic             ex_valid,
   output logic [2:0]       ex_ALUOp,
   output logic             ex_RegDest,
   output logic             ex_RegWrite,
   output logic             ex_ALUSrc,
   output logic             ex_MemRead,
   output logic             ex_MemWrite,
   output logic             ex_MemToReg,
   output logic             ex_Branch,
   output logic             ex_Jump,
   output logic [31:0]      ex_pc4,
   output logic [31:0]      ex_rdata1,
   output logic [31:0]      ex_rdata2,
   output logic [31:0]      ex_imm,
   output logic [4:0]       ex_rs,
   output logic [4:0]       ex_rt,
   output logic [4:0]       ex_rd,
   output logic [5:0]       ex_funct,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic        valid;
      logic [2:0]  alu_op;
      logic        reg_dest;
      logic        reg_write;
      logic        alu_src;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
      logic        jump;
      logic [31:0] pc4;
      logic [31:0] rdata1;
      logic [31:0] rdata2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [5:0]  funct;
   } id_ex_t;

   id_ex_t           ex_q;
   id_ex_t           ex_d;
   logic             hz;
   logic             rt_use;
   logic             bubble;
   logic [CNT_W-1:0] cnt_q;

   // rt is a source only for R-type ops and as store data
   assign rt_use = ~id_ALUSrc | id_MemWrite;

   assign hz = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0)
             & id_valid
             & ((ex_q.rt == id_rs) | ((ex_q.rt == id_rt) & rt_use));

   assign stall  = hz & ~flush;
   assign bubble = hz | flush;

   always_comb begin
      ex_d = '0;
      if (!bubble) begin
         ex_d.valid  = id_valid;
         ex_d.pc4    = id_pc4;
         ex_d.rdata1 = id_rdata1;
         ex_d.rdata2 = id_rdata2;
         ex_d.imm    = id_imm;
         ex_d.rs     = id_rs;
         ex_d.rt     = id_rt;
         ex_d.rd     = id_rd;
         ex_d.funct  = id_funct;
         // empty slots carry no control, whatever decode produced
         if (id_valid) begin
            ex_d.alu_op     = id_ALUOp;
            ex_d.reg_dest   = id_RegDest;
            ex_d.reg_write  = id_RegWrite;
            ex_d.alu_src    = id_ALUSrc;
            ex_d.mem_read   = id_MemRead;
            ex_d.mem_write  = id_MemWrite;
            ex_d.mem_to_reg = id_MemToReg;
            ex_d.branch     = id_Branch;
            ex_d.jump       = id_Jump;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_ALUOp    = ex_q.alu_op;
   assign ex_RegDest  = ex_q.reg_dest;
   assign ex_RegWrite = ex_q.reg_write;
   assign ex_ALUSrc   = ex_q.alu_src;
   assign ex_MemRead  = ex_q.mem_read;
   assign ex_MemWrite = ex_q.mem_write;
   assign ex_MemToReg = ex_q.mem_to_reg;
   assign ex_Branch   = ex_q.branch;
   assign ex_Jump     = ex_q.jump;
   assign ex_pc4      = ex_q.pc4;
   assign ex_rdata1   = ex_q.rdata1;
   assign ex_rdata2   = ex_q.rdata2;
   assign ex_imm      = ex_q.imm;
   assign ex_rs       = ex_q.rs;
   assign ex_rt       = ex_q.rt;
   assign ex_rd       = ex_q.rd;
   assign ex_funct    = ex_q.funct;
   assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard cases plus random traffic
// checked against a cycle-level reference model.
module tb_id_ex_stage;

   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          id_valid;
   logic [2:0]    id_ALUOp;
   logic [7:0]    id_c;
   logic          id_RegDest, id_RegWrite, id_ALUSrc, id_MemRead;
   logic          id_MemWrite, id_MemToReg, id_Branch, id_Jump;
   logic [31:0]   id_pc4, id_rdata1, id_rdata2, id_imm;
   logic [4:0]    id_rs, id_rt, id_rd;
   logic [5:0]    id_funct;
   logic          flush;
   logic          ex_valid;
   logic [2:0]    ex_ALUOp;
   logic          ex_RegDest, ex_RegWrite, ex_ALUSrc, ex_MemRead;
   logic          ex_MemWrite, ex_MemToReg, ex_Branch, ex_Jump;
   logic [31:0]   ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
   logic [4:0]    ex_rs, ex_rt, ex_rd;
   logic [5:0]    ex_funct;
   logic          stall;
   logic [CW-1:0] stall_cnt;

   // control vector order: RegDest RegWrite ALUSrc MemRead MemWrite MemToReg Branch Jump
   assign {id_RegDest, id_RegWrite, id_ALUSrc, id_MemRead,
           id_MemWrite, id_MemToReg, id_Branch, id_Jump} = id_c;

   localparam logic [7:0] C_RTYPE = 8'b1100_0000;
   localparam logic [7:0] C_LW    = 8'b0111_0100;
   localparam logic [7:0] C_SW    = 8'b0010_1000;
   localparam logic [7:0] C_ADDI  = 8'b0110_0000;

   id_ex_stage #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ALUOp(id_ALUOp),
      .id_RegDest(id_RegDest), .id_RegWrite(id_RegWrite),
      .id_ALUSrc(id_ALUSrc), .id_MemRead(id_MemRead),
      .id_MemWrite(id_MemWrite), .id_MemToReg(id_MemToReg),
      .id_Branch(id_Branch), .id_Jump(id_Jump),
      .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_funct(id_funct), .flush(flush),
      .ex_valid(ex_valid), .ex_ALUOp(ex_ALUOp),
      .ex_RegDest(ex_RegDest), .ex_RegWrite(ex_RegWrite),
      .ex_ALUSrc(ex_ALUSrc), .ex_MemRead(ex_MemRead),
      .ex_MemWrite(ex_MemWrite), .ex_MemToReg(ex_MemToReg),
      .ex_Branch(ex_Branch), .ex_Jump(ex_Jump),
      .ex_pc4(ex_pc4), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
      .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_funct(ex_funct), .stall(stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int ncmp  = 0;
   int nfail = 0;

   // reference model of the EX slot and the counter
   logic        m_v;
   logic [2:0]  m_op;
   logic        m_opk;
   logic [7:0]  m_c;
   logic [31:0] m_pc4, m_r1, m_r2, m_imm;
   logic [4:0]  m_rs, m_rt, m_rd;
   logic [5:0]  m_fn;
   int          m_cnt;

   task automatic chk(input string tag, input logic [63:0] o,
                      input logic [63:0] e);
      ncmp++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic m_clear();
      m_v = 0; m_op = 0; m_opk = 1; m_c = 0;
      m_pc4 = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_fn = 0;
      m_cnt = 0;
   endtask

   function automatic logic m_hz();
      logic rt_src;
      rt_src = !id_ALUSrc || id_MemWrite;
      return m_v && m_c[4] && (m_rt != 0) && id_valid &&
             ((m_rt == id_rs) || ((m_rt == id_rt) && rt_src));
   endfunction

   task automatic drive(input logic v, input logic [2:0] op,
                        input logic [7:0] c, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic fl);
      id_valid = v; id_ALUOp = op; id_c = c;
      id_pc4 = $urandom; id_rdata1 = r1; id_rdata2 = r2; id_imm = imm;
      id_rs = rs; id_rt = rt; id_rd = rd; id_funct = 6'($urandom);
      flush = fl;
   endtask

   task automatic check_ex();
      chk("ctl", {55'd0, ex_valid, ex_RegDest, ex_RegWrite, ex_ALUSrc,
                  ex_MemRead, ex_MemWrite, ex_MemToReg, ex_Branch, ex_Jump},
                 {55'd0, m_v, m_c});
      if (m_opk) chk("aluop", 64'(ex_ALUOp), 64'(m_op));
      chk("pc4", 64'(ex_pc4), 64'(m_pc4));
      chk("rdata1", 64'(ex_rdata1), 64'(m_r1));
      chk("rdata2", 64'(ex_rdata2), 64'(m_r2));
      chk("imm", 64'(ex_imm), 64'(m_imm));
      chk("idx", 64'({ex_rs, ex_rt, ex_rd, ex_funct}),
                 64'({m_rs, m_rt, m_rd, m_fn}));
      chk("cnt", 64'(stall_cnt), 64'(m_cnt));
   endtask

   // one cycle: inputs already driven just after a rising edge
   task automatic cyc();
      logic h;
      #3;
      h = m_hz();
      chk("stall", 64'(stall), 64'(h && !flush));
      @(posedge clk);
      if (h && !flush && m_cnt < CMAX) m_cnt++;
      if (h || flush) begin
         m_v = 0; m_op = 0; m_opk = 1; m_c = 0;
         m_pc4 = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
         m_rs = 0; m_rt = 0; m_rd = 0; m_fn = 0;
      end else begin
         m_v = id_valid; m_op = id_ALUOp; m_opk = id_valid;
         m_c = id_valid ? id_c : 8'd0;
         m_pc4 = id_pc4; m_r1 = id_rdata1; m_r2 = id_rdata2;
         m_imm = id_imm; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
         m_fn = id_funct;
      end
      #1;
      check_ex();
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(ex_valid), 64'd0);
      chk("rst_cnt", 64'(stall_cnt), 64'd0);
      rst_n = 1'b1;
      m_clear();
   endtask

   int exp_seq[4] = '{1, 2, 3, 3};

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      m_clear();
      #2;
      chk("reset_stall", 64'(stall), 64'd0);
      check_ex();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // R-type, no hazard
      drive(1, 3'b010, C_RTYPE, 32'h5, 32'h7, 32'hFFFF_FFFC, 1, 2, 3, 0);
      cyc();
      chk("rtype_rdata1", 64'(ex_rdata1), 64'h5);
      chk("rtype_imm", 64'(ex_imm), 64'hFFFF_FFFC);
      chk("rtype_regdest", 64'(ex_RegDest), 64'd1);
      chk("rtype_aluop", 64'(ex_ALUOp), 64'd2);

      // lw r8 followed by dependent add
      drive(1, 0, C_LW, 0, 0, 4, 1, 8, 0, 0);
      cyc();
      drive(1, 3'b010, C_RTYPE, 1, 2, 0, 8, 9, 10, 0);
      #3;
      chk("lu_stall", 64'(stall), 64'd1);
      #1;
      @(posedge clk);
      #1;
      chk("lu_bub_valid", 64'(ex_valid), 64'd0);
      chk("lu_bub_rw", 64'(ex_RegWrite), 64'd0);
      chk("lu_cnt", 64'(stall_cnt), 64'd1);
      m_clear();
      m_cnt = 1;
      cyc();
      chk("lu_add_in", 64'({ex_valid, ex_rs}), 64'({1'b1, 5'd8}));

      // same hazard under flush
      drive(1, 0, C_LW, 0, 0, 4, 1, 8, 0, 0);
      cyc();
      drive(1, 3'b010, C_RTYPE, 1, 2, 0, 8, 9, 10, 1);
      cyc();
      chk("fl_valid", 64'(ex_valid), 64'd0);
      chk("fl_cnt", 64'(stall_cnt), 64'd1);

      // register-0 and source-usage cases
      drive(1, 0, C_LW, 0, 0, 4, 1, 0, 0, 0);
      cyc();
      drive(1, 3'b010, C_RTYPE, 1, 2, 0, 0, 0, 10, 0);
      cyc();
      drive(1, 0, C_LW, 0, 0, 4, 1, 8, 0, 0);
      cyc();
      drive(1, 0, C_ADDI, 1, 0, 9, 1, 8, 0, 0);
      cyc();
      chk("addi_nostall", 64'(ex_valid), 64'd1);
      drive(1, 0, C_LW, 0, 0, 4, 1, 8, 0, 0);
      cyc();
      drive(1, 0, C_SW, 1, 2, 8, 1, 8, 0, 0);
      cyc();
      chk("sw_cnt", 64'(stall_cnt), 64'd2);
      cyc();

      // counter saturation over four load-use pairs
      pulse_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, C_LW, 0, 0, 4, 1, 5, 0, 0);
         cyc();
         drive(1, 3'b010, C_RTYPE, 1, 2, 0, 3, 5, 6, 0);
         cyc();
         chk("sat_seq", 64'(stall_cnt), 64'(exp_seq[k]));
         cyc();
      end

      // random traffic
      for (int n = 0; n < 400; n++) begin
         if (n % 80 == 79) pulse_reset();
         drive($urandom_range(7) != 0, 3'($urandom),
               {$urandom_range(1) == 0 ? 8'($urandom) | 8'h10
                                       : 8'($urandom) & 8'hEF},
               $urandom, $urandom, $urandom,
               5'($urandom_range(3)), 5'($urandom_range(3)),
               5'($urandom), $urandom_range(7) == 0);
         cyc();
      end

      // async reset in the middle of a stall
      drive(1, 0, C_LW, 0, 0, 4, 1, 7, 0, 0);
      cyc();
      drive(1, 3'b010, C_RTYPE, 1, 2, 0, 7, 1, 2, 0);
      #3;
      chk("mid_stall", 64'(stall), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("ar_stall", 64'(stall), 64'd0);
      chk("ar_valid", 64'(ex_valid), 64'd0);
      chk("ar_memread", 64'(ex_MemRead), 64'd0);
      chk("ar_cnt", 64'(stall_cnt), 64'd0);
      rst_n = 1'b1;
      m_clear();
      @(posedge clk);
      #1;
      chk("ar_resume", 64'({ex_valid, ex_rs}), 64'({1'b1, 5'd7}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall-event counter.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have id_valid  input  1  ID slot holds a real instruction.
REQ-005 SHALL have id_ALUOp  input  3  ALU operation from control unit.
REQ-006 SHALL have id_RegDest, id_RegWrite, id_ALUSrc, id_MemRead, id_MemWrite, id_MemToReg, id_Branch, id_Jump  input  1 each  control unit outputs.
REQ-007 SHALL have id_pc4, id_rdata1, id_rdata2, id_imm  input  32 each  PC+4, register-file reads, sign-extended immediate.
REQ-008 SHALL have id_rs, id_rt, id_rd  input  5 each; id_funct  input  6.
REQ-009 SHALL have flush  input  1  kill the ID instruction (branch/jump resolved taken).
REQ-010 SHALL have ex_* outputs (ex_valid, ex_ALUOp, ex_RegDest ... ex_Jump, ex_pc4, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct), widths matching their id_* counterparts, registered.
REQ-011 SHALL have stall  output  1  combinational; hold PC and IF/ID register this cycle.
REQ-012 SHALL have stall_cnt  output  CNT_W  count of stall cycles, saturating.

Function
REQ-013 SHALL detect load-use hazard: hz = ex_valid & ex_MemRead & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | ((ex_rt == id_rt) & (~id_ALUSrc | id_MemWrite))).
REQ-014 SHALL drive stall = hz & ~flush; flush overrides stall in the same cycle.
REQ-015 SHALL, when flush=1 or hz=1 at a rising edge, load a bubble: ex_valid=0, all ex_ control bits=0, ex_ALUOp=0, all ex_ data/index fields=0.
REQ-016 SHALL, otherwise, load every ex_ field from its id_ counterpart, ex_valid=id_valid, one-cycle latency.
REQ-017 SHALL, when id_valid=0 and no bubble, force all ex_ control bits to 0 regardless of id_ inputs (x-free bubbles); data fields still loaded.
REQ-018 SHALL never assert stall for two consecutive cycles for the same load (bubble clears ex_MemRead, so hz drops next cycle).
REQ-019 SHALL increment stall_cnt by 1 on each rising edge with stall=1; hold at 2^CNT_W-1 when saturated.
REQ-020 SHALL not count cycles where flush=1 suppressed a hazard.
REQ-021 SHALL treat id_rs/id_rt equal to 0 as never hazardous via the ex_rt != 0 term only (no other register-0 special case).

Reset
REQ-022 SHALL, while rst_n=0, asynchronously set ex_valid=0, all ex_ fields=0, stall_cnt=0.
REQ-023 SHALL output stall=0 during and immediately after reset (follows from ex_valid=0).
REQ-024 SHALL, on reset assertion mid-stall, drop stall within the same cycle and resume normal loading on the first edge after rst_n rises.

Verification
REQ-025 SHALL pass: lw in EX (ex_MemRead=1, ex_rt=8), ID add with id_rs=8, id_valid=1 -> stall=1, next edge ex_valid=0, ex_RegWrite=0, stall_cnt=1; following cycle stall=0, add enters EX.
REQ-026 SHALL pass: same hazard with flush=1 -> stall=0, bubble loaded, stall_cnt unchanged.
REQ-027 SHALL pass: lw ex_rt=0, ID id_rs=0 -> stall=0; ID addi with id_rt=8, id_ALUSrc=1, ex_rt=8 -> stall=0; sw with id_rt=8 -> stall=1.
REQ-028 SHALL pass: Rtype with id_rdata1=0x0000_0005, id_imm=0xFFFF_FFFC, no hazard -> one edge later ex_rdata1=5, ex_imm=0xFFFF_FFFC, ex_RegDest=1, ex_ALUOp=3'b010.
REQ-029 SHALL pass: CNT_W=2, four consecutive load-use pairs -> stall_cnt sequence 1,2,3,3.
REQ-030 SHALL pass: rst_n pulsed low between edges while ex_valid=1 -> ex_valid=0 and stall_cnt=0 immediately, without waiting for clk.
